// File: rtl/spi_slave_fl_if.sv
// SPI pins plus the decoded-frame backend bus of the flash-style SPI responder.
interface spi_slave_fl_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 24
);
    logic              sclk;
    logic              ss;
    logic              mosi;
    logic              miso;
    logic [7:0]        cmd;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic [2:0]        frame_type;
    logic              frame_valid;
    logic              frame_err;
    logic              rd_req;
    logic [DATA_W-1:0] rd_data;
    logic [DATA_W-1:0] status;
    logic              busy;

    modport slave (
        input  sclk, ss, mosi, rd_data, status,
        output miso, cmd, addr, wdata, frame_type, frame_valid, frame_err, rd_req, busy
    );

    modport master (
        output sclk, ss, mosi, rd_data, status,
        input  miso, cmd, addr, wdata, frame_type, frame_valid, frame_err, rd_req, busy
    );
endinterface

// File: rtl/spi_slave_fl.sv
// SPI mode-0 flash-style responder: oversamples the SPI pins in the clk domain,
// decodes command/address/data frames and answers RDSR/READ on miso (LSB first).
module spi_slave_fl #(
    parameter int         DATA_W   = 32,
    parameter int         ADDR_W   = 24,
    parameter logic [7:0] CMD_WRSR = 8'h01,
    parameter logic [7:0] CMD_PP   = 8'h02,
    parameter logic [7:0] CMD_READ = 8'h03,
    parameter logic [7:0] CMD_RDSR = 8'h05
) (
    input logic           clk,
    input logic           rst,
    spi_slave_fl_if.slave bus
);
    typedef enum logic [2:0] {WAIT_SS, IDLE, CMD, ADDR, DIN, DOUT, SINK} state_t;

    localparam logic [5:0] CMD_LAST  = 6'd7;
    localparam logic [5:0] ADDR_LAST = 6'(ADDR_W - 1);
    localparam logic [5:0] DATA_LAST = 6'(DATA_W - 1);
    localparam logic [5:0] DATA_FULL = 6'(DATA_W);
    localparam logic [2:0] T_SINK = 3'd0, T_RDSR = 3'd1, T_READ = 3'd2, T_WRSR = 3'd3, T_PP = 3'd4;

    logic [2:0] sclk_pipe_reg, ss_pipe_reg;
    logic [1:0] mosi_pipe_reg, settle_reg;
    logic       sclk_sync, ss_sync, mosi_sync, rise, fall, ss_fall, ss_rise;

    state_t            state_reg, state_next;
    logic [5:0]        bitcnt_reg, bitcnt_next;
    logic [DATA_W-1:0] shift_reg, shift_next, shifted;
    logic [7:0]        cmd_pend_reg, cmd_pend_next, cmd_reg, cmd_next;
    logic [ADDR_W-1:0] addr_pend_reg, addr_pend_next, addr_reg, addr_next;
    logic [DATA_W-1:0] wdata_pend_reg, wdata_pend_next, wdata_reg, wdata_next;
    logic [2:0]        type_pend_reg, type_pend_next, frame_type_reg, frame_type_next;
    logic              frame_valid_reg, frame_valid_next, frame_err_reg, frame_err_next;
    logic              rd_req_reg, rd_req_next, rd_pend_reg;
    logic              in_frame, frame_ok;

    assign sclk_sync = sclk_pipe_reg[1];
    assign ss_sync   = ss_pipe_reg[1];
    assign mosi_sync = mosi_pipe_reg[1];
    assign rise      = sclk_sync & ~sclk_pipe_reg[2];
    assign fall      = ~sclk_sync & sclk_pipe_reg[2];
    assign ss_fall   = ~ss_sync & ss_pipe_reg[2];
    assign ss_rise   = ss_sync & ~ss_pipe_reg[2];
    assign in_frame  = (state_reg != WAIT_SS) && (state_reg != IDLE);
    assign shifted   = {shift_reg[DATA_W-2:0], mosi_sync};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sclk_pipe_reg   <= '0;
            ss_pipe_reg     <= '1;
            mosi_pipe_reg   <= '0;
            settle_reg      <= '0;
            state_reg       <= WAIT_SS;
            bitcnt_reg      <= '0;
            shift_reg       <= '0;
            cmd_pend_reg    <= '0;
            addr_pend_reg   <= '0;
            wdata_pend_reg  <= '0;
            type_pend_reg   <= '0;
            cmd_reg         <= '0;
            addr_reg        <= '0;
            wdata_reg       <= '0;
            frame_type_reg  <= '0;
            frame_valid_reg <= 1'b0;
            frame_err_reg   <= 1'b0;
            rd_req_reg      <= 1'b0;
            rd_pend_reg     <= 1'b0;
        end else begin
            sclk_pipe_reg   <= {sclk_pipe_reg[1:0], bus.sclk};
            ss_pipe_reg     <= {ss_pipe_reg[1:0], bus.ss};
            mosi_pipe_reg   <= {mosi_pipe_reg[0], bus.mosi};
            settle_reg      <= {settle_reg[0], 1'b1};
            state_reg       <= state_next;
            bitcnt_reg      <= bitcnt_next;
            shift_reg       <= shift_next;
            cmd_pend_reg    <= cmd_pend_next;
            addr_pend_reg   <= addr_pend_next;
            wdata_pend_reg  <= wdata_pend_next;
            type_pend_reg   <= type_pend_next;
            cmd_reg         <= cmd_next;
            addr_reg        <= addr_next;
            wdata_reg       <= wdata_next;
            frame_type_reg  <= frame_type_next;
            frame_valid_reg <= frame_valid_next;
            frame_err_reg   <= frame_err_next;
            rd_req_reg      <= rd_req_next;
            rd_pend_reg     <= rd_req_reg;
        end
    end

    always_comb begin
        state_next       = state_reg;
        bitcnt_next      = bitcnt_reg;
        shift_next       = shift_reg;
        cmd_pend_next    = cmd_pend_reg;
        addr_pend_next   = addr_pend_reg;
        wdata_pend_next  = wdata_pend_reg;
        type_pend_next   = type_pend_reg;
        cmd_next         = cmd_reg;
        addr_next        = addr_reg;
        wdata_next       = wdata_reg;
        frame_type_next  = frame_type_reg;
        frame_valid_next = 1'b0;
        frame_err_next   = 1'b0;
        rd_req_next      = 1'b0;
        frame_ok         = 1'b0;

        if (ss_rise && in_frame) begin
            // Decoded fields are only published for a well-formed frame.
            state_next  = IDLE;
            bitcnt_next = '0;
            frame_ok    = (state_reg == SINK) || (state_reg == DOUT) ||
                          ((state_reg == DIN) && (bitcnt_reg >= DATA_FULL));
            frame_valid_next = frame_ok;
            frame_err_next   = ~frame_ok;
            if (frame_ok) begin
                cmd_next        = cmd_pend_reg;
                frame_type_next = type_pend_reg;
                if (type_pend_reg == T_READ || type_pend_reg == T_PP)
                    addr_next = addr_pend_reg;
                if (type_pend_reg == T_WRSR || type_pend_reg == T_PP)
                    wdata_next = wdata_pend_reg;
            end
        end else begin
            case (state_reg)
                // The settle delay keeps the reset value of the ss chain from
                // being mistaken for a deasserted select after reset.
                WAIT_SS: if (ss_sync && settle_reg[1]) state_next = IDLE;
                IDLE: if (ss_fall) begin
                    state_next  = CMD;
                    bitcnt_next = '0;
                end
                CMD: if (rise) begin
                    shift_next  = shifted;
                    bitcnt_next = bitcnt_reg + 6'd1;
                    if (bitcnt_reg == CMD_LAST) begin
                        cmd_pend_next = shifted[7:0];
                        bitcnt_next   = '0;
                        if (shifted[7:0] == CMD_READ) begin
                            state_next = ADDR; type_pend_next = T_READ;
                        end else if (shifted[7:0] == CMD_PP) begin
                            state_next = ADDR; type_pend_next = T_PP;
                        end else if (shifted[7:0] == CMD_WRSR) begin
                            state_next = DIN;  type_pend_next = T_WRSR;
                        end else if (shifted[7:0] == CMD_RDSR) begin
                            state_next = DOUT; type_pend_next = T_RDSR;
                            shift_next = bus.status;
                        end else begin
                            state_next = SINK; type_pend_next = T_SINK;
                        end
                    end
                end
                ADDR: if (rise) begin
                    shift_next  = shifted;
                    bitcnt_next = bitcnt_reg + 6'd1;
                    if (bitcnt_reg == ADDR_LAST) begin
                        addr_pend_next = shifted[ADDR_W-1:0];
                        bitcnt_next    = '0;
                        if (type_pend_reg == T_PP) begin
                            state_next = DIN;
                        end else begin
                            state_next  = DOUT;
                            rd_req_next = 1'b1;
                        end
                    end
                end
                DIN: if (rise && bitcnt_reg < DATA_FULL) begin
                    shift_next  = shifted;
                    bitcnt_next = bitcnt_reg + 6'd1;
                    if (bitcnt_reg == DATA_LAST) wdata_pend_next = shifted;
                end
                DOUT: begin
                    // bitcnt counts response rises; the fall closing the last
                    // input bit must not consume response bit 0.
                    if (rise && bitcnt_reg < DATA_FULL) bitcnt_next = bitcnt_reg + 6'd1;
                    if (fall && bitcnt_reg != 6'd0)     shift_next  = {1'b0, shift_reg[DATA_W-1:1]};
                end
                SINK: if (rise && bitcnt_reg < DATA_FULL) bitcnt_next = bitcnt_reg + 6'd1;
                default: state_next = WAIT_SS;
            endcase
            if (rd_pend_reg) shift_next = bus.rd_data;
        end
    end

    assign bus.miso        = (state_reg == DOUT && !ss_sync) ? shift_reg[0] : 1'b0;
    assign bus.busy        = in_frame;
    assign bus.cmd         = cmd_reg;
    assign bus.addr        = addr_reg;
    assign bus.wdata       = wdata_reg;
    assign bus.frame_type  = frame_type_reg;
    assign bus.frame_valid = frame_valid_reg;
    assign bus.frame_err   = frame_err_reg;
    assign bus.rd_req      = rd_req_reg;
endmodule

// File: tb/tb_spi_slave_fl.sv
// Directed bench for spi_slave_fl: table of frames plus reset-mid-frame sequence.
module tb_spi_slave_fl;
    localparam int HALF = 4;  // sclk half period in clk cycles (sclk = clk/8)

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    spi_slave_fl_if #(.DATA_W(32), .ADDR_W(24)) bus ();
    spi_slave_fl #(.DATA_W(32), .ADDR_W(24)) dut (.clk(clk), .rst(rst), .bus(bus.slave));

    typedef struct {
        logic [7:0]  c;     int cmd_bits;
        logic [23:0] a;     int addr_bits;
        logic [31:0] d;     int data_bits;
        logic [31:0] status;
        logic [31:0] rdword;
        int          exp_valid, exp_err, exp_rdreq;
        logic [2:0]  exp_type;
        logic [7:0]  exp_cmd;
        logic [23:0] exp_addr;
        logic [31:0] exp_wdata;
        bit          chk_miso;
        logic [31:0] exp_miso;
    } vec_t;

    int errors = 0, checks = 0;
    int valid_cnt = 0, err_cnt = 0, rdreq_cnt = 0;

    always @(posedge clk) begin
        if (bus.frame_valid) valid_cnt <= valid_cnt + 1;
        if (bus.frame_err)   err_cnt   <= err_cnt + 1;
        if (bus.rd_req)      rdreq_cnt <= rdreq_cnt + 1;
    end

    initial begin
        #5ms;
        $display("FAIL watchdog: simulation did not finish, got timeout required completion");
        $fatal(1, "watchdog");
    end

    function automatic vec_t mk(logic [7:0] c, int cb, logic [23:0] a, int ab,
                                logic [31:0] d, int db, logic [31:0] st, logic [31:0] rw,
                                int ev, int ee, int er, logic [2:0] et, logic [7:0] ec,
                                logic [23:0] ea, logic [31:0] ew, bit cm, logic [31:0] em);
        vec_t v;
        v.c = c; v.cmd_bits = cb; v.a = a; v.addr_bits = ab; v.d = d; v.data_bits = db;
        v.status = st; v.rdword = rw; v.exp_valid = ev; v.exp_err = ee; v.exp_rdreq = er;
        v.exp_type = et; v.exp_cmd = ec; v.exp_addr = ea; v.exp_wdata = ew;
        v.chk_miso = cm; v.exp_miso = em;
        return v;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h required %0h", name, act, exp);
        end
    endtask

    task automatic half();
        repeat (HALF) @(negedge clk);
    endtask

    // One sclk period: drive mosi while low, sample miso just before the rise.
    task automatic send_bit(input logic b, output logic m);
        bus.mosi = b;
        half();
        m = bus.miso;
        bus.sclk = 1'b1;
        half();
        bus.sclk = 1'b0;
    endtask

    task automatic run_frame(input vec_t v, input int idx);
        int v0, e0, r0, total;
        logic [63:0] got, mask;
        logic b, m;
        v0 = valid_cnt; e0 = err_cnt; r0 = rdreq_cnt;
        got = '0;
        bus.status  = v.status;
        bus.rd_data = '0;
        total = v.cmd_bits + v.addr_bits + v.data_bits;
        bus.ss = 1'b0;
        half();
        fork
            begin
                for (int i = 0; i < total; i++) begin
                    int j;
                    j = i - v.cmd_bits - v.addr_bits;
                    if (i < v.cmd_bits)                    b = v.c[7 - i];
                    else if (i < v.cmd_bits + v.addr_bits) b = v.a[23 - (i - v.cmd_bits)];
                    else if (j < 32)                       b = v.d[31 - j];
                    else                                   b = 1'b1;
                    send_bit(b, m);
                    if (j >= 0 && j < 64) got[j] = m;
                end
            end
            begin
                if (v.exp_rdreq != 0) begin
                    for (int k = 0; k < 4000; k++) begin
                        @(negedge clk);
                        if (bus.rd_req) begin
                            bus.rd_data = v.rdword;
                            break;
                        end
                    end
                end
            end
        join
        half();
        bus.ss = 1'b1;
        repeat (4 * HALF) @(negedge clk);
        chk($sformatf("v%0d frame_valid", idx), 64'(valid_cnt - v0), 64'(v.exp_valid));
        chk($sformatf("v%0d frame_err", idx),   64'(err_cnt - e0),   64'(v.exp_err));
        chk($sformatf("v%0d rd_req", idx),      64'(rdreq_cnt - r0), 64'(v.exp_rdreq));
        chk($sformatf("v%0d frame_type", idx),  64'(bus.frame_type), 64'(v.exp_type));
        chk($sformatf("v%0d cmd", idx),         64'(bus.cmd),        64'(v.exp_cmd));
        chk($sformatf("v%0d addr", idx),        64'(bus.addr),       64'(v.exp_addr));
        chk($sformatf("v%0d wdata", idx),       64'(bus.wdata),      64'(v.exp_wdata));
        chk($sformatf("v%0d busy idle", idx),   64'(bus.busy),       64'd0);
        chk($sformatf("v%0d miso idle", idx),   64'(bus.miso),       64'd0);
        if (v.chk_miso) begin
            mask = (v.data_bits >= 64) ? '1 : ((64'd1 << v.data_bits) - 64'd1);
            chk($sformatf("v%0d miso word", idx), got & mask, {32'h0, v.exp_miso} & mask);
        end
        $display("frame %0d: cmd=%h valid=%0d err=%0d rd_req=%0d type=%0d addr=%h wdata=%h miso=%h",
                 idx, v.c, valid_cnt - v0, err_cnt - e0, rdreq_cnt - r0,
                 bus.frame_type, bus.addr, bus.wdata, got[31:0]);
    endtask

    initial begin
        vec_t vecs[10];
        vec_t post;
        logic [7:0]  rc;
        logic [23:0] ra;
        logic        m;
        int v0, e0, r0;

        //              cmd   cb  addr        ab  data          db  status        rdword        v e r  type  cmd   addr        wdata         miso  expected miso
        vecs[0] = mk(8'h05, 8, 24'h0,      0, 32'h0,        40, 32'hA5A5_00FF, 32'h0,       1,0,0, 3'd1, 8'h05, 24'h000000, 32'h0,        1, 32'hA5A5_00FF);
        vecs[1] = mk(8'h03, 8, 24'h123456, 24, 32'h0,       32, 32'h0,        32'hDEAD_BEEF, 1,0,1, 3'd2, 8'h03, 24'h123456, 32'h0,        1, 32'hDEAD_BEEF);
        vecs[2] = mk(8'h02, 8, 24'h000010, 24, 32'hCAFE_F00D, 32, 32'h0,      32'h0,        1,0,0, 3'd4, 8'h02, 24'h000010, 32'hCAFE_F00D, 0, 32'h0);
        vecs[3] = mk(8'h01, 8, 24'h0,      0, 32'h1234_5678, 20, 32'h0,       32'h0,        0,1,0, 3'd4, 8'h02, 24'h000010, 32'hCAFE_F00D, 0, 32'h0);
        vecs[4] = mk(8'h9F, 8, 24'h0,      0, 32'hFFFF_FFFF, 8, 32'h0,        32'h0,        1,0,0, 3'd0, 8'h9F, 24'h000010, 32'hCAFE_F00D, 0, 32'h0);
        vecs[5] = mk(8'h01, 8, 24'h0,      0, 32'h0BAD_C0DE, 32, 32'h0,       32'h0,        1,0,0, 3'd3, 8'h01, 24'h000010, 32'h0BAD_C0DE, 0, 32'h0);
        vecs[6] = mk(8'h03, 5, 24'h0,      0, 32'h0,        0, 32'h0,         32'h0,        0,1,0, 3'd3, 8'h01, 24'h000010, 32'h0BAD_C0DE, 0, 32'h0);
        vecs[7] = mk(8'h02, 8, 24'hABCDEF, 12, 32'h0,       0, 32'h0,         32'h0,        0,1,0, 3'd3, 8'h01, 24'h000010, 32'h0BAD_C0DE, 0, 32'h0);
        vecs[8] = mk(8'h03, 8, 24'hABCDEF, 24, 32'h0,       32, 32'h0,        32'h8000_0001, 1,0,1, 3'd2, 8'h03, 24'hABCDEF, 32'h0BAD_C0DE, 1, 32'h8000_0001);
        vecs[9] = mk(8'h02, 8, 24'h00FFEE, 24, 32'h1357_9BDF, 36, 32'h0,      32'h0,        1,0,0, 3'd4, 8'h02, 24'h00FFEE, 32'h1357_9BDF, 0, 32'h0);
        post    = mk(8'h05, 8, 24'h0,      0, 32'h0,        32, 32'h1234_5678, 32'h0,       1,0,0, 3'd1, 8'h05, 24'h000000, 32'h0,        1, 32'h1234_5678);

        rst = 1'b1;
        bus.sclk = 1'b0; bus.ss = 1'b1; bus.mosi = 1'b0;
        bus.status = '0; bus.rd_data = '0;
        repeat (3) @(negedge clk);
        chk("reset cmd",         64'(bus.cmd),         64'd0);
        chk("reset addr",        64'(bus.addr),        64'd0);
        chk("reset wdata",       64'(bus.wdata),       64'd0);
        chk("reset frame_type",  64'(bus.frame_type),  64'd0);
        chk("reset frame_valid", 64'(bus.frame_valid), 64'd0);
        chk("reset frame_err",   64'(bus.frame_err),   64'd0);
        chk("reset rd_req",      64'(bus.rd_req),      64'd0);
        chk("reset busy",        64'(bus.busy),        64'd0);
        chk("reset miso",        64'(bus.miso),        64'd0);
        rst = 1'b0;
        repeat (8) @(negedge clk);

        for (int i = 0; i < 10; i++) run_frame(vecs[i], i);

        // Reset during the address phase of a READ; the tail of that frame is ignored.
        v0 = valid_cnt; e0 = err_cnt; r0 = rdreq_cnt;
        rc = 8'h03; ra = 24'h654321;
        bus.ss = 1'b0;
        half();
        for (int i = 0; i < 8; i++)  send_bit(rc[7 - i], m);
        for (int i = 0; i < 10; i++) send_bit(ra[23 - i], m);
        chk("midrst busy before", 64'(bus.busy), 64'd1);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        chk("midrst cmd",        64'(bus.cmd),        64'd0);
        chk("midrst addr",       64'(bus.addr),       64'd0);
        chk("midrst wdata",      64'(bus.wdata),      64'd0);
        chk("midrst frame_type", 64'(bus.frame_type), 64'd0);
        chk("midrst busy",       64'(bus.busy),       64'd0);
        rst = 1'b0;
        for (int i = 10; i < 24; i++) send_bit(ra[23 - i], m);
        for (int i = 0; i < 32; i++)  send_bit(1'b0, m);
        half();
        chk("midrst busy tail", 64'(bus.busy), 64'd0);
        chk("midrst miso tail", 64'(bus.miso), 64'd0);
        bus.ss = 1'b1;
        repeat (4 * HALF) @(negedge clk);
        chk("midrst no valid",  64'(valid_cnt - v0), 64'd0);
        chk("midrst no err",    64'(err_cnt - e0),   64'd0);
        chk("midrst no rd_req", 64'(rdreq_cnt - r0), 64'd0);
        $display("frame reset-mid-read: valid=%0d err=%0d rd_req=%0d",
                 valid_cnt - v0, err_cnt - e0, rdreq_cnt - r0);

        run_frame(post, 10);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
